// File: rtl/fmap_reader.sv
// fmap_reader: streams packed 64-bit feature-map words from two BRAM32k read ports
// as signed byte pairs (A,B) over a valid/ready handshake, with a one-word prefetch
// per port so the stream runs at one pair per cycle once primed.
// Build option: define RD_RELU_EN to clamp negative output bytes to zero.
module fmap_reader #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned BASE_A = 0,
  parameter int unsigned BASE_B = 32,
  parameter int unsigned WORDS  = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              en_BRAM32k,
  output logic [ADDR_W-1:0] addr_BRAM32k_1,
  output logic [ADDR_W-1:0] addr_BRAM32k_2,
  input  logic [63:0]       dout_BRAM32k_1,
  input  logic [63:0]       dout_BRAM32k_2,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic [7:0]        byteA,
  output logic [7:0]        byteB,
  output logic              byte_last,
  output logic              busy,
  output logic              FinishRD
);

  localparam int unsigned       CntW  = $clog2(WORDS + 1);
  localparam logic [ADDR_W-1:0] BaseA = ADDR_W'(BASE_A);
  localparam logic [ADDR_W-1:0] BaseB = ADDR_W'(BASE_B);

  typedef enum logic [1:0] {StIdle, StFill, StStream, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr1_q, addr1_d, addr2_q, addr2_d;
  logic [CntW-1:0]   issued_q, issued_d;
  logic [CntW-1:0]   consumed_q, consumed_d;
  logic [RD_LAT-1:0] pend_q, pend_d;
  logic              cur_valid_q, cur_valid_d;
  logic              pf_valid_q, pf_valid_d;
  logic [63:0]       cur_a_q, cur_a_d, cur_b_q, cur_b_d;
  logic [63:0]       pf_a_q, pf_a_d, pf_b_q, pf_b_d;
  logic [2:0]        idx_q, idx_d;

  logic run_active, issue, capture, xfer, last_pair, promote;

  function automatic logic [7:0] rd_clamp(input logic [7:0] b);
`ifdef RD_RELU_EN
    return b[7] ? 8'h00 : b;
`else
    return b;
`endif
  endfunction

  // Datapath control: one read in flight at most, and only while the prefetch slot is free.
  assign run_active = (state_q == StFill) || (state_q == StStream);
  assign issue      = run_active && !pf_valid_q && (pend_q == '0) &&
                      (issued_q < CntW'(WORDS));
  assign capture    = pend_q[RD_LAT-1];
  assign xfer       = cur_valid_q && byte_ready;
  assign last_pair  = cur_valid_q && (idx_q == 3'd7) && (consumed_q == CntW'(WORDS - 1));
  assign promote    = xfer && (idx_q == 3'd7);

  // Next-state logic for the FSM, read pipeline, word registers and byte index.
  always_comb begin
    state_d     = state_q;
    addr1_d     = addr1_q;
    addr2_d     = addr2_q;
    issued_d    = issued_q;
    consumed_d  = consumed_q;
    cur_valid_d = cur_valid_q;
    pf_valid_d  = pf_valid_q;
    cur_a_d     = cur_a_q;
    cur_b_d     = cur_b_q;
    pf_a_d      = pf_a_q;
    pf_b_d      = pf_b_q;
    idx_d       = idx_q;
    pend_d      = '0;

    // Shift register tracking the in-flight read; the top bit marks the capture cycle.
    pend_d[0] = issue;
    for (int unsigned k = 1; k < RD_LAT; k++) begin
      pend_d[k] = pend_q[k-1];
    end

    if (issue) begin
      addr1_d  = addr1_q + ADDR_W'(1);
      addr2_d  = addr2_q + ADDR_W'(1);
      issued_d = issued_q + CntW'(1);
    end

    if (xfer) begin
      idx_d = idx_q + 3'd1;
    end

    // Prefetch word takes over in the same cycle the last byte leaves, so no bubble.
    if (promote) begin
      cur_valid_d = pf_valid_q;
      cur_a_d     = pf_a_q;
      cur_b_d     = pf_b_q;
      pf_valid_d  = 1'b0;
      consumed_d  = consumed_q + CntW'(1);
    end

    if (capture) begin
      if (!cur_valid_q || (promote && !pf_valid_q)) begin
        cur_valid_d = 1'b1;
        cur_a_d     = dout_BRAM32k_1;
        cur_b_d     = dout_BRAM32k_2;
      end else begin
        pf_valid_d = 1'b1;
        pf_a_d     = dout_BRAM32k_1;
        pf_b_d     = dout_BRAM32k_2;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (start) state_d = StFill;
      end
      StFill: begin
        if (capture) state_d = StStream;
      end
      StStream: begin
        if (xfer && last_pair) state_d = StDone;
      end
      StDone: begin
        state_d     = StIdle;
        addr1_d     = BaseA;
        addr2_d     = BaseB;
        issued_d    = '0;
        consumed_d  = '0;
        idx_d       = '0;
        cur_valid_d = 1'b0;
        pf_valid_d  = 1'b0;
        pend_d      = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; async reset also drops any read still in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      addr1_q     <= BaseA;
      addr2_q     <= BaseB;
      issued_q    <= '0;
      consumed_q  <= '0;
      pend_q      <= '0;
      cur_valid_q <= 1'b0;
      pf_valid_q  <= 1'b0;
      cur_a_q     <= '0;
      cur_b_q     <= '0;
      pf_a_q      <= '0;
      pf_b_q      <= '0;
      idx_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr1_q     <= addr1_d;
      addr2_q     <= addr2_d;
      issued_q    <= issued_d;
      consumed_q  <= consumed_d;
      pend_q      <= pend_d;
      cur_valid_q <= cur_valid_d;
      pf_valid_q  <= pf_valid_d;
      cur_a_q     <= cur_a_d;
      cur_b_q     <= cur_b_d;
      pf_a_q      <= pf_a_d;
      pf_b_q      <= pf_b_d;
      idx_q       <= idx_d;
    end
  end

  // Output decode: bytes are zero whenever no pair is valid.
  always_comb begin
    en_BRAM32k     = issue;
    addr_BRAM32k_1 = addr1_q;
    addr_BRAM32k_2 = addr2_q;
    byte_valid     = cur_valid_q;
    byte_last      = last_pair;
    busy           = (state_q != StIdle);
    FinishRD       = (state_q == StDone);
    byteA          = 8'h00;
    byteB          = 8'h00;
    if (cur_valid_q) begin
      byteA = rd_clamp(cur_a_q[{idx_q, 3'b000} +: 8]);
      byteB = rd_clamp(cur_b_q[{idx_q, 3'b000} +: 8]);
    end
  end

endmodule

// File: tb/tb_fmap_reader.sv
// Bench for fmap_reader: behavioural BRAMs, a scoreboard of expected byte pairs,
// and one task per scenario. Two instances: WORDS=2/RD_LAT=1 and WORDS=1/RD_LAT=2.
module tb_fmap_reader;

  localparam int unsigned BaseA = 0;
  localparam int unsigned BaseB = 32;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       last;
  } pair_t;

  logic        clk, rst;
  logic        start, byte_ready;
  logic        en_BRAM32k;
  logic [11:0] addr_1, addr_2;
  logic [63:0] dout_1, dout_2;
  logic        byte_valid, byte_last, busy, FinishRD;
  logic [7:0]  byteA, byteB;

  logic        u2_start, u2_ready, u2_en, u2_valid, u2_last, u2_busy, u2_finish;
  logic [11:0] u2_addr_1, u2_addr_2;
  logic [63:0] u2_dout_1, u2_dout_2, u2_s1_1, u2_s1_2;
  logic [7:0]  u2_byteA, u2_byteB;

  logic [63:0] mem1 [0:63];
  logic [63:0] mem2 [0:63];

  pair_t sb_q[$];
  int    n_vec   = 0;
  int    n_err   = 0;
  int    en_cnt1 = 0;
  int    en_cnt2 = 0;

  fmap_reader #(.ADDR_W(12), .BASE_A(BaseA), .BASE_B(BaseB), .WORDS(2), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .en_BRAM32k(en_BRAM32k),
    .addr_BRAM32k_1(addr_1), .addr_BRAM32k_2(addr_2),
    .dout_BRAM32k_1(dout_1), .dout_BRAM32k_2(dout_2),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .byteA(byteA), .byteB(byteB),
    .byte_last(byte_last), .busy(busy), .FinishRD(FinishRD)
  );

  fmap_reader #(.ADDR_W(12), .BASE_A(BaseA), .BASE_B(BaseB), .WORDS(1), .RD_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .start(u2_start), .en_BRAM32k(u2_en),
    .addr_BRAM32k_1(u2_addr_1), .addr_BRAM32k_2(u2_addr_2),
    .dout_BRAM32k_1(u2_dout_1), .dout_BRAM32k_2(u2_dout_2),
    .byte_valid(u2_valid), .byte_ready(u2_ready), .byteA(u2_byteA), .byteB(u2_byteB),
    .byte_last(u2_last), .busy(u2_busy), .FinishRD(u2_finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle BRAM for dut, two-cycle BRAM for dut2; enable pulses are counted.
  always @(posedge clk) begin
    if (en_BRAM32k) begin
      dout_1  <= mem1[addr_1[5:0]];
      dout_2  <= mem2[addr_2[5:0]];
      en_cnt1 <= en_cnt1 + 1;
    end
    if (u2_en) begin
      u2_s1_1 <= mem1[u2_addr_1[5:0]];
      u2_s1_2 <= mem2[u2_addr_2[5:0]];
      en_cnt2 <= en_cnt2 + 1;
    end
    u2_dout_1 <= u2_s1_1;
    u2_dout_2 <= u2_s1_2;
  end

  // Expected pairs for the default memory image: A byte 8w+i, B byte 16+8w+i.
  task automatic push_seq(input int n);
    pair_t p;
    for (int w = 0; w < n; w++) begin
      for (int i = 0; i < 8; i++) begin
        p.a    = 8'(8 * w + i);
        p.b    = 8'(16 + 8 * w + i);
        p.last = (w == n - 1) && (i == 7);
        sb_q.push_back(p);
      end
    end
  endtask

  // Drives one run on dut from a negedge; pat gives byte_ready per valid cycle (bit 0 first).
  task automatic run_stream(input logic [3:0] pat, input int mid_start, input int abort_after,
                            output int first_cyc, output int last_cyc,
                            output logic [11:0] addr_mid);
    int    cyc, p, xfers;
    bit    hold, done, aborted, mid_done, mid_rec;
    pair_t obs, prev, exp;
    cyc = 0; p = 0; xfers = 0; hold = 0; done = 0; aborted = 0; mid_done = 0; mid_rec = 0;
    first_cyc = -1; last_cyc = -1; addr_mid = '0; prev = '0;
    start = 1'b1; byte_ready = 1'b1;
    @(negedge clk);
    cyc = 1;
    while (!done && !aborted && cyc < 300) begin
      start = 1'b0;
      if (mid_done && !mid_rec) begin
        addr_mid = addr_1;
        mid_rec  = 1;
      end
      obs = {byteA, byteB, byte_last};
      if (hold) begin
        n_vec++;
        if (!byte_valid || obs !== prev) begin
          n_err++;
          $display("FAIL hold_stable: got valid=%b pair=%h, required valid=1 pair=%h",
                   byte_valid, obs, prev);
        end
      end
      if (byte_valid && first_cyc < 0) first_cyc = cyc;
      byte_ready = byte_valid ? pat[p % 4] : 1'b1;
      if (byte_valid) p++;
      if (byte_valid && byte_ready) begin
        xfers++;
        last_cyc = cyc;
        n_vec++;
        if (sb_q.size() == 0) begin
          n_err++;
          $display("FAIL pair_extra: got %h, required no further pair", obs);
        end else begin
          exp = sb_q.pop_front();
          if (obs !== exp) begin
            n_err++;
            $display("FAIL pair_%0d: got A=%h B=%h last=%b, required A=%h B=%h last=%b",
                     xfers, obs.a, obs.b, obs.last, exp.a, exp.b, exp.last);
          end
        end
        if (byte_last) done = 1;
      end
      hold = byte_valid && !byte_ready;
      prev = obs;
      if (abort_after >= 0 && xfers == abort_after) aborted = 1;
      if (mid_start >= 0 && !mid_done && xfers == mid_start) begin
        start    = 1'b1;
        mid_done = 1;
      end
      @(negedge clk);
      cyc++;
    end
    start      = 1'b0;
    byte_ready = 1'b1;
    if (!aborted) begin
      n_vec++;
      if (!done) begin
        n_err++;
        $display("FAIL run_timeout: got no byte_last after %0d cycles, required a last pair", cyc);
      end else if (FinishRD !== 1'b1 || busy !== 1'b1) begin
        n_err++;
        $display("FAIL finish_pulse: got FinishRD=%b busy=%b, required 1 1", FinishRD, busy);
      end
    end
  endtask

  task automatic test_reset;
    n_vec++;
    if ({byte_valid, byte_last, busy, FinishRD, en_BRAM32k, byteA, byteB} !== '0 ||
        addr_1 !== 12'(BaseA) || addr_2 !== 12'(BaseB)) begin
      n_err++;
      $display("FAIL reset_state: got v=%b l=%b busy=%b fin=%b en=%b A=%h B=%h a1=%0d a2=%0d, required zeros a1=0 a2=32",
               byte_valid, byte_last, busy, FinishRD, en_BRAM32k, byteA, byteB, addr_1, addr_2);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || u2_busy !== 1'b0) begin
      n_err++;
      $display("FAIL idle_after_reset: got busy=%b/%b, required 0/0", busy, u2_busy);
    end
  endtask

  task automatic test_basic;
    int f, l, e0;
    logic [11:0] am;
    sb_q.delete();
    push_seq(2);
    e0 = en_cnt1;
    run_stream(4'b1111, -1, -1, f, l, am);
    n_vec++;
    if (f !== 3) begin
      n_err++;
      $display("FAIL first_valid_lat1: got cycle %0d, required 3", f);
    end
    n_vec++;
    if (l - f !== 15) begin
      n_err++;
      $display("FAIL full_rate: got %0d cycles first-to-last, required 15", l - f);
    end
    n_vec++;
    if (en_cnt1 - e0 !== 2 || sb_q.size() !== 0) begin
      n_err++;
      $display("FAIL basic_reads: got en=%0d left=%0d, required en=2 left=0",
               en_cnt1 - e0, sb_q.size());
    end
    // start landing in the FinishRD cycle must not begin a new run
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) begin
      n_vec++;
      if (busy !== 1'b0 || FinishRD !== 1'b0 || en_BRAM32k !== 1'b0) begin
        n_err++;
        $display("FAIL start_at_finish: got busy=%b fin=%b en=%b, required 0 0 0",
                 busy, FinishRD, en_BRAM32k);
      end
      @(negedge clk);
    end
    n_vec++;
    if (addr_1 !== 12'(BaseA) || addr_2 !== 12'(BaseB)) begin
      n_err++;
      $display("FAIL addr_reload: got %0d/%0d, required %0d/%0d", addr_1, addr_2, BaseA, BaseB);
    end
  endtask

  task automatic test_backpressure;
    int f, l, e0;
    logic [11:0] am;
    sb_q.delete();
    push_seq(2);
    e0 = en_cnt1;
    run_stream(4'b1001, -1, -1, f, l, am);
    n_vec++;
    if (en_cnt1 - e0 !== 2 || sb_q.size() !== 0) begin
      n_err++;
      $display("FAIL bp_reads: got en=%0d left=%0d, required en=2 left=0",
               en_cnt1 - e0, sb_q.size());
    end
    @(negedge clk);
  endtask

  task automatic test_start_busy;
    int f, l, e0;
    logic [11:0] am;
    sb_q.delete();
    push_seq(2);
    e0 = en_cnt1;
    run_stream(4'b1111, 10, -1, f, l, am);
    n_vec++;
    if (am !== 12'(BaseA + 2)) begin
      n_err++;
      $display("FAIL busy_start_addr: got addr_1=%0d, required %0d", am, BaseA + 2);
    end
    n_vec++;
    if (en_cnt1 - e0 !== 2 || sb_q.size() !== 0) begin
      n_err++;
      $display("FAIL busy_start_reads: got en=%0d left=%0d, required en=2 left=0",
               en_cnt1 - e0, sb_q.size());
    end
    @(negedge clk);
  endtask

  task automatic test_words1_lat2;
    int    cyc, first, xf, e0;
    bit    done;
    pair_t obs, exp;
    sb_q.delete();
    push_seq(1);
    e0 = en_cnt2;
    u2_start = 1'b1; u2_ready = 1'b1;
    @(negedge clk);
    u2_start = 1'b0;
    cyc = 1; first = -1; xf = 0; done = 0;
    while (!done && cyc < 100) begin
      if (u2_valid && first < 0) first = cyc;
      if (u2_valid) begin
        xf++;
        obs = {u2_byteA, u2_byteB, u2_last};
        exp = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
        n_vec++;
        if (obs !== exp) begin
          n_err++;
          $display("FAIL w1_pair_%0d: got %h, required %h", xf, obs, exp);
        end
        if (u2_last) done = 1;
      end
      @(negedge clk);
      cyc++;
    end
    n_vec++;
    if (first !== 4) begin
      n_err++;
      $display("FAIL first_valid_lat2: got cycle %0d, required 4", first);
    end
    n_vec++;
    if (!done || xf !== 8 || en_cnt2 - e0 !== 1 || u2_finish !== 1'b1) begin
      n_err++;
      $display("FAIL w1_run: got last=%b pairs=%0d en=%0d fin=%b, required 1 8 1 1",
               done, xf, en_cnt2 - e0, u2_finish);
    end
    u2_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_midrun;
    int f, l;
    logic [11:0] am;
    sb_q.delete();
    push_seq(2);
    run_stream(4'b1111, -1, 3, f, l, am);
    rst = 1'b0;
    #1;
    n_vec++;
    if ({byte_valid, byte_last, busy, FinishRD, en_BRAM32k, byteA, byteB} !== '0 ||
        addr_1 !== 12'(BaseA) || addr_2 !== 12'(BaseB)) begin
      n_err++;
      $display("FAIL midrun_reset: got v=%b busy=%b A=%h B=%h a1=%0d a2=%0d, required zeros a1=0 a2=32",
               byte_valid, busy, byteA, byteB, addr_1, addr_2);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if (byte_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL no_late_capture: got valid=%b busy=%b, required 0 0", byte_valid, busy);
    end
    sb_q.delete();
    push_seq(2);
    run_stream(4'b1111, -1, -1, f, l, am);
    n_vec++;
    if (f !== 3 || sb_q.size() !== 0) begin
      n_err++;
      $display("FAIL rerun_after_reset: got first=%0d left=%0d, required 3 0", f, sb_q.size());
    end
    @(negedge clk);
  endtask

  task automatic test_relu;
    int          f, l;
    logic [11:0] am;
    logic [7:0]  tab [8];
    pair_t       p;
`ifdef RD_RELU_EN
    tab = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h01, 8'h7F, 8'h00, 8'h00};
`else
    tab = '{8'h02, 8'h81, 8'hFE, 8'h00, 8'h01, 8'h7F, 8'hFF, 8'h80};
`endif
    mem1[0] = 64'h80FF7F01_00FE8102;
    sb_q.delete();
    for (int i = 0; i < 8; i++) begin
      p.a = tab[i]; p.b = 8'(16 + i); p.last = 1'b0;
      sb_q.push_back(p);
    end
    for (int i = 0; i < 8; i++) begin
      p.a = 8'(8 + i); p.b = 8'(24 + i); p.last = (i == 7);
      sb_q.push_back(p);
    end
    run_stream(4'b1111, -1, -1, f, l, am);
    n_vec++;
    if (sb_q.size() !== 0) begin
      n_err++;
      $display("FAIL relu_left: got %0d pairs unseen, required 0", sb_q.size());
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; byte_ready = 1'b0; u2_start = 1'b0; u2_ready = 1'b0;
    for (int j = 0; j < 64; j++) begin
      mem1[j] = '0;
      mem2[j] = '0;
    end
    mem1[0]  = 64'h0706050403020100;
    mem1[1]  = 64'h0F0E0D0C0B0A0908;
    mem2[32] = 64'h1716151413121110;
    mem2[33] = 64'h1F1E1D1C1B1A1918;
    repeat (2) @(negedge clk);
    test_reset;
    test_basic;
    test_backpressure;
    test_start_busy;
    test_words1_lat2;
    test_reset_midrun;
    test_relu;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
